// File: rtl/spi_rx_packer_pkg.sv
// Shared types and constants for the SPI receive packer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package spi_rx_packer_pkg;

    // Width of one received byte.
    localparam int BYTE_W = 8;

    // Assembler states: IDLE while cs_n is high, COLLECT inside a frame.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_rx_packer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout shows the head entry, forced to 0 when empty.
// Latency: a push is visible at dout one edge after it is presented.
// Backpressure: push while full is taken only if a pop happens on the same edge; pop while empty is ignored.
module sync_fifo
    import spi_rx_packer_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          din,
    input  logic                   pop,
    output logic [DW-1:0]          dout,
    output logic                   empty,
    output logic                   full,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          wr_en, rd_en;

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

    // Storage array: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_packer.sv
// Packs bytes received within a cs_n frame into words and buffers them in a FWFT FIFO; SPI_PACKER_SOF_EN adds word_sof.
// Latency: last byte sampled at edge N, word in FIFO and visible at edge N+1.
// Backpressure: none upstream; a completed word arriving at a full FIFO without a pop is dropped and sets sticky overflow.
module spi_rx_packer
    import spi_rx_packer_pkg::*;
#(
    parameter int BYTES_PER_WORD = 2,
    parameter int DEPTH          = 8,
    parameter int MSB_FIRST      = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cs_n,
    input  logic [BYTE_W-1:0]                  byte_in,
    input  logic                               byte_valid,
    output logic [BYTE_W*BYTES_PER_WORD-1:0]   word_out,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic [clog2(DEPTH):0]              level,
    output logic                               overflow,
`ifdef SPI_PACKER_SOF_EN
    output logic                               word_sof,
`endif
    input  logic                               clr_ovf
);

    localparam int WW = BYTE_W * BYTES_PER_WORD;
`ifdef SPI_PACKER_SOF_EN
    localparam int DW = WW + 1;
`else
    localparam int DW = WW;
`endif

    state_t        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [WW-1:0] asm_q, asm_d;
    logic [WW-1:0] pdat_q, pdat_d;
    logic          push_q, push_d;
    logic          ovf_q, ovf_d;
    logic [WW-1:0] byte_ext, asm_shift;
    logic          byte_take, word_done;
    logic          fifo_empty, fifo_full, fifo_pop;
    logic [DW-1:0] fifo_din, fifo_dout;
`ifdef SPI_PACKER_SOF_EN
    logic          first_q, first_d;
    logic          psof_q, psof_d;
`endif

    // A byte counts only while cs_n is low; a strobe with cs_n high is ignored.
    assign byte_take = !cs_n && byte_valid;
    assign byte_ext  = WW'(byte_in);
    assign asm_shift = (MSB_FIRST != 0) ? ((asm_q << BYTE_W) | byte_ext)
                                        : ((asm_q >> BYTE_W) | (byte_ext << (WW - BYTE_W)));
    assign word_done = byte_take && ((bcnt_q + 3'd1) == 3'(BYTES_PER_WORD));

    // Assembler next-state: frame tracking, byte shifting, push request generation.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        pdat_d  = pdat_q;
        push_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bcnt_d = '0;
                if (!cs_n) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                    bcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bcnt_d  = '0;
            end
        endcase
        if (byte_take) begin
            asm_d = asm_shift;
            if (word_done) begin
                push_d = 1'b1;
                pdat_d = asm_shift;
                bcnt_d = '0;
            end else begin
                bcnt_d = bcnt_q + 3'd1;
            end
        end
    end

`ifdef SPI_PACKER_SOF_EN
    // Start-of-frame tag: first completed word after cs_n goes low.
    always_comb begin
        first_d = first_q;
        psof_d  = psof_q;
        if (cs_n) begin
            first_d = 1'b1;
        end else if (word_done) begin
            psof_d  = first_q;
            first_d = 1'b0;
        end
    end

    // Start-of-frame tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b1;
            psof_q  <= 1'b0;
        end else begin
            first_q <= first_d;
            psof_q  <= psof_d;
        end
    end

    assign fifo_din = {psof_q, pdat_q};
    assign word_sof = fifo_dout[WW];
`else
    assign fifo_din = pdat_q;
`endif

    // Overflow is sticky; a drop on the same edge as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        if (push_q && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Assembler and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            asm_q   <= '0;
            pdat_q  <= '0;
            push_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            pdat_q  <= pdat_d;
            push_q  <= push_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fifo_pop = word_ready && !fifo_empty;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (fifo_din),
        .pop   (word_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign word_out   = fifo_dout[WW-1:0];
    assign word_valid = !fifo_empty;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_spi_rx_packer.sv
module tb_spi_rx_packer;

    logic        clk = 1'b0;
    logic        rst, cs_n, byte_valid, word_ready, clr_ovf;
    logic [7:0]  byte_in;
    logic [15:0] wout_m, wout_l;
    logic        wvld_m, wvld_l, ovf_m, ovf_l;
    logic [3:0]  lvl_m, lvl_l;
`ifdef SPI_PACKER_SOF_EN
    logic        sof_m, sof_l;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    logic [15:0] q_msb[$];
    logic [15:0] q_lsb[$];
    logic        q_sof[$];
    logic [15:0] m_msb, m_lsb;
    int          m_cnt, m_level;
    logic        m_first, exp_ovf;

    always #5 clk = ~clk;

    spi_rx_packer #(.BYTES_PER_WORD(2), .DEPTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .cs_n(cs_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .word_out(wout_m), .word_valid(wvld_m), .word_ready(word_ready),
        .level(lvl_m), .overflow(ovf_m),
`ifdef SPI_PACKER_SOF_EN
        .word_sof(sof_m),
`endif
        .clr_ovf(clr_ovf)
    );

    spi_rx_packer #(.BYTES_PER_WORD(2), .DEPTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .cs_n(cs_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .word_out(wout_l), .word_valid(wvld_l), .word_ready(word_ready),
        .level(lvl_l), .overflow(ovf_l),
`ifdef SPI_PACKER_SOF_EN
        .word_sof(sof_l),
`endif
        .clr_ovf(clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_lvl_m"}, 32'(lvl_m), 32'(m_level));
        chk({tag, "_lvl_l"}, 32'(lvl_l), 32'(m_level));
        chk({tag, "_ovf_m"}, 32'(ovf_m), 32'(exp_ovf));
        chk({tag, "_ovf_l"}, 32'(ovf_l), 32'(exp_ovf));
        chk({tag, "_vld_m"}, 32'(wvld_m), 32'(m_level != 0));
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        tick();
        m_cnt   = 0;
        m_first = 1'b1;
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        tick();
        m_cnt   = 0;
        m_first = 1'b1;
    endtask

    // will_pop: the consumer pops on the edge this word is pushed
    task automatic send_byte(input logic [7:0] b, input logic will_pop);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        m_msb = {m_msb[7:0], b};
        m_lsb = {b, m_lsb[15:8]};
        m_cnt++;
        if (m_cnt == 2) begin
            m_cnt = 0;
            if (m_level < 8 || will_pop) begin
                q_msb.push_back(m_msb);
                q_lsb.push_back(m_lsb);
                q_sof.push_back(m_first);
                m_level++;
            end else begin
                exp_ovf = 1'b1;
            end
            m_first = 1'b0;
        end
    endtask

    task automatic pop_word(input string tag);
        if (q_msb.size() == 0) begin
            chk({tag, "_unexpected_vld"}, 32'(wvld_m), 32'd0);
        end else begin
            chk({tag, "_vld_m"}, 32'(wvld_m), 32'd1);
            chk({tag, "_vld_l"}, 32'(wvld_l), 32'd1);
            chk({tag, "_dat_m"}, 32'(wout_m), 32'(q_msb[0]));
            chk({tag, "_dat_l"}, 32'(wout_l), 32'(q_lsb[0]));
`ifdef SPI_PACKER_SOF_EN
            chk({tag, "_sof_m"}, 32'(sof_m), 32'(q_sof[0]));
            chk({tag, "_sof_l"}, 32'(sof_l), 32'(q_sof[0]));
`endif
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
            void'(q_sof.pop_front());
            m_level--;
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cs_n = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        word_ready = 1'b0; clr_ovf = 1'b0;
        m_msb = '0; m_lsb = '0; m_cnt = 0; m_level = 0; m_first = 1'b1; exp_ovf = 1'b0;
        repeat (3) tick();
        chk("rst_wout_m", 32'(wout_m), 32'd0);
        chk("rst_wout_l", 32'(wout_l), 32'd0);
        check_state("rst");
        rst = 1'b0;
        tick();

        // Basic packing with latency: not visible after edge N, visible after N+1
        frame_start();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        chk("lat_vld_early", 32'(wvld_m), 32'd0);
        chk("lat_lvl_early", 32'(lvl_m), 32'd0);
        tick();
        check_state("basic");
        chk("basic_const_m", 32'(wout_m), 32'h0000A53C);
        pop_word("basic");

        // Byte order
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        tick();
        chk("order_const_l", 32'(wout_l), 32'h00003412);
        pop_word("order");
        frame_end();

        // Frame abort: partial word discarded
        frame_start();
        send_byte(8'h11, 1'b0);
        frame_end();
        frame_start();
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        tick();
        check_state("abort");
        chk("abort_const_m", 32'(wout_m), 32'h00002233);
        pop_word("abort");
        tick();
        check_state("abort_drained");

        // Ignored strobe while cs_n high
        frame_end();
        cs_n = 1'b1; byte_in = 8'hEE; byte_valid = 1'b1; tick(); byte_valid = 1'b0;
        frame_start();
        send_byte(8'h5A, 1'b0);
        send_byte(8'h69, 1'b0);
        tick();
        chk("csn_hi_ignored", 32'(wout_m), 32'h00005A69);
        pop_word("csn_hi");

        // Overflow: 9 words without popping
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(8'h40 + 2 * i), 1'b0);
            send_byte(8'(8'h41 + 2 * i), 1'b0);
        end
        tick();
        check_state("ovf");
        chk("ovf_head_m", 32'(wout_m), 32'h00004041);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        check_state("clr_ovf");

        // Full with simultaneous pop and push
        send_byte(8'hC0, 1'b0);
        send_byte(8'hDE, 1'b1);
        pop_word("simpop");
        check_state("simpop_after");
        for (int i = 0; i < 8; i++) begin
            pop_word($sformatf("drain%0d", i));
        end
        check_state("drained");
        // word_ready while empty: no effect
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check_state("ready_empty");
        frame_end();

        // Start-of-frame: 4-byte frame gives two words
        frame_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        tick();
        frame_end();
        check_state("sof");
        pop_word("sof0");
        pop_word("sof1");

        // Reset mid-frame with 3 words buffered
        frame_start();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h90 + i), 1'b0);
        end
        send_byte(8'h99, 1'b0);
        tick();
        check_state("prerst");
        rst = 1'b1;
        cs_n = 1'b1;
        tick();
        rst = 1'b0;
        q_msb.delete(); q_lsb.delete(); q_sof.delete();
        m_level = 0; m_cnt = 0; exp_ovf = 1'b0; m_first = 1'b1;
        chk("midrst_wout_m", 32'(wout_m), 32'd0);
        chk("midrst_wout_l", 32'(wout_l), 32'd0);
        check_state("midrst");

        // After reset a fresh frame starts cleanly
        frame_start();
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        tick();
        check_state("postrst");
        pop_word("postrst");
        frame_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
